pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16; max cycles spent in MEM_WAIT before FAULT.
REQ-002 Parameter CNT_W, default 16; stall counter width.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 id_rs1, id_rs2  in  5 each  source register indices in ID.
REQ-007 ex_rd  in  5  destination register index in EX.
REQ-008 ex_mem_read  in  1  load instruction in EX.
REQ-009 ex_branch_taken  in  1  resolved taken branch or jump in EX.
REQ-010 mem_req  in  1  MEM stage instruction needs data memory.
REQ-011 dmem_ack  in  1  data memory completes the access this cycle.
REQ-012 pc_ld, id_ld, ex_ld, mem_ld, wb_ld  out  1 each  load enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
REQ-013 flush_id, flush_ex  out  1 each  synchronous clear of IF/ID and ID/EX; takes priority over ld at the register.
REQ-014 dmem_req  out  1  data memory request.
REQ-015 fault  out  1  sticky memory-timeout error.
REQ-016 stall_cnt  out  CNT_W  count of cycles with pc_ld=0.

Function
REQ-017 The FSM SHALL have states RUN, MEM_WAIT and FAULT.
REQ-018 Outputs SHALL be combinational from state and inputs; state, wait counter and stall_cnt SHALL be registered.
REQ-019 In RUN, when mem_req=1, dmem_req SHALL be 1.
REQ-020 In RUN, mem_req=1 with dmem_ack=0 SHALL drive all five ld=0 and both flushes 0, and SHALL move the FSM to MEM_WAIT with the wait counter cleared.
REQ-021 In RUN, mem_req=1 with dmem_ack=1 SHALL NOT stall; normal hazard rules apply.
REQ-022 In MEM_WAIT, dmem_req SHALL be 1, all ld SHALL be 0, flushes SHALL be 0, and the wait counter SHALL increment each cycle.
REQ-023 In MEM_WAIT, dmem_ack=1 SHALL drive all ld=1, apply the branch flush if ex_branch_taken=1, and return to RUN.
REQ-024 In MEM_WAIT, a wait counter of MEM_TIMEOUT-1 with dmem_ack=0 SHALL move the FSM to FAULT.
REQ-025 In FAULT, all ld, flushes and dmem_req SHALL be 0 and fault SHALL be 1 until reset.
REQ-026 Load-use is ex_mem_read=1, ex_rd!=0 and ex_rd equal to id_rs1 or id_rs2.
REQ-027 On load-use in RUN with no memory stall: pc_ld=0, id_ld=0, flush_ex=1, and ex_ld=mem_ld=wb_ld=1 (one bubble per occurrence).
REQ-028 When ex_branch_taken=1 and the pipeline advances: flush_id=1, flush_ex=1, all ld=1.
REQ-029 Priority SHALL be memory stall > branch flush > load-use; a branch suppresses a simultaneous load-use stall.
REQ-030 Otherwise, in RUN all ld SHALL be 1 and flushes 0.
REQ-031 stall_cnt SHALL increment on each clock edge where pc_ld=0 outside reset, saturating at all-ones.

Reset
REQ-032 Asserting reset SHALL force state RUN, wait counter 0, stall_cnt 0 and fault 0.
REQ-033 While reset=1, all ld, flushes and dmem_req SHALL be 0, including when reset is asserted mid-MEM_WAIT.
REQ-034 On the first edge after reset deasserts, the block SHALL operate from RUN.

Structure
REQ-035 A shared package SHALL hold the ctrl_state_e enum (RUN, MEM_WAIT, FAULT) and default constants for MEM_TIMEOUT and CNT_W.
REQ-036 Load-use comparison SHALL be a combinational sub-module, load_use_detect.

Verification
REQ-037 Load-use case: ex_mem_read=1, ex_rd=5, id_rs2=5, no mem_req -> exactly one cycle of pc_ld=0, id_ld=0, flush_ex=1; stall_cnt=1.
REQ-038 Same as REQ-037 with ex_rd=0 -> no stall, all ld=1.
REQ-039 Delayed ack: mem_req=1 and dmem_ack arriving 3 cycles later -> all ld=0 for 3 cycles, then all ld=1 with the FSM in RUN; stall_cnt=3.
REQ-040 Branch plus load-use: ex_branch_taken=1 with the REQ-037 load-use condition -> flush_id=1, flush_ex=1, all ld=1, no stall.
REQ-041 Timeout: mem_req=1 with dmem_ack held 0 -> FAULT after 1+16 cycles with fault=1 and all outputs 0; reset clears fault.
REQ-042 Reset mid-MEM_WAIT: asserting reset asynchronously -> outputs 0 immediately; after release, RUN with stall_cnt=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } ctrl_state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W_DEF       = 16;

  // Bit order of the packed load-enable vector: {pc, id, ex, mem, wb}.
  localparam logic [4:0] LD_ALL      = 5'b11111;
  localparam logic [4:0] LD_NONE     = 5'b00000;
  localparam logic [4:0] LD_LOAD_USE = 5'b00111;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the EX load and ID sources.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rd_nonzero;
  logic src_match;

  always_comb begin
    rd_nonzero = (ex_rd != 5'd0);
    src_match  = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    load_use   = ex_mem_read && rd_nonzero && src_match;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: memory-stall FSM with timeout fault, branch flush,
// load-use bubble insertion and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             pc_ld,
  output logic             id_ld,
  output logic             ex_ld,
  output logic             mem_ld,
  output logic             wb_ld,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             dmem_req,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              load_use;

  logic [4:0] ld;
  logic       fl_id, fl_ex, dreq, flt;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    ld        = LD_NONE;
    fl_id     = 1'b0;
    fl_ex     = 1'b0;
    dreq      = 1'b0;
    flt       = 1'b0;

    unique case (state)
      RUN: begin
        dreq = mem_req;
        // Memory stall outranks branch flush, which outranks load-use.
        if (mem_req && !dmem_ack) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = '0;
        end else if (ex_branch_taken) begin
          ld    = LD_ALL;
          fl_id = 1'b1;
          fl_ex = 1'b1;
        end else if (load_use) begin
          ld    = LD_LOAD_USE;
          fl_ex = 1'b1;
        end else begin
          ld = LD_ALL;
        end
      end

      MEM_WAIT: begin
        dreq = 1'b1;
        if (dmem_ack) begin
          ld        = LD_ALL;
          fl_id     = ex_branch_taken;
          fl_ex     = ex_branch_taken;
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = FAULT;
          end
        end
      end

      FAULT: begin
        flt = 1'b1;
      end

      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase

    // Reset clears state asynchronously, but the outputs must also read
    // zero for the whole time reset is held, not just RUN-derived values.
    if (reset) begin
      ld    = LD_NONE;
      fl_id = 1'b0;
      fl_ex = 1'b0;
      dreq  = 1'b0;
      flt   = 1'b0;
    end
  end

  always_comb begin
    pc_ld    = ld[4];
    id_ld    = ld[3];
    ex_ld    = ld[2];
    mem_ld   = ld[1];
    wb_ld    = ld[0];
    flush_id = fl_id;
    flush_ex = fl_ex;
    dmem_req = dreq;
    fault    = flt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_ld && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random stimulus
// checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          ex_mem_read, ex_branch_taken, mem_req, dmem_ack;
  logic          pc_ld, id_ld, ex_ld, mem_ld, wb_ld;
  logic          flush_id, flush_ex, dmem_req, fault;
  logic [CW-1:0] stall_cnt;
  logic [8:0]    act;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .dmem_ack        (dmem_ack),
    .pc_ld           (pc_ld),
    .id_ld           (id_ld),
    .ex_ld           (ex_ld),
    .mem_ld          (mem_ld),
    .wb_ld           (wb_ld),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .dmem_req        (dmem_req),
    .fault           (fault),
    .stall_cnt       (stall_cnt)
  );

  // Output vector order: pc, id, ex, mem, wb, flush_id, flush_ex, dmem_req, fault
  assign act = {pc_ld, id_ld, ex_ld, mem_ld, wb_ld, flush_id, flush_ex, dmem_req, fault};

  typedef struct packed {
    logic [8:0]    outs;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: pipeline is either flowing, waiting on memory, or dead.
  bit m_waiting;
  bit m_faulted;
  int m_wait_cycles;
  int m_stalls;

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mr, input logic br,
                      input logic mq, input logic ack);
    logic [8:0] e;
    bit lu;
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_mem_read = mr; ex_branch_taken = br; mem_req = mq; dmem_ack = ack;

    lu = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    if (rst) begin
      m_waiting = 0; m_faulted = 0; m_wait_cycles = 0; m_stalls = 0;
      e = '0;
    end else if (m_faulted) begin
      e = 9'b000000001;
    end else if (m_waiting) begin
      if (ack) begin
        e = {5'b11111, br, br, 1'b1, 1'b0};
        m_waiting = 0;
      end else begin
        e = 9'b000000010;
        m_wait_cycles++;
        if (m_wait_cycles == TO) begin
          m_waiting = 0;
          m_faulted = 1;
        end
      end
    end else if (mq && !ack) begin
      e = 9'b000000010;
      m_waiting = 1;
      m_wait_cycles = 0;
    end else if (br) begin
      e = {5'b11111, 1'b1, 1'b1, mq, 1'b0};
    end else if (lu) begin
      e = {5'b00111, 1'b0, 1'b1, mq, 1'b0};
    end else begin
      e = {5'b11111, 1'b0, 1'b0, mq, 1'b0};
    end

    x.outs = e;
    x.cnt  = CW'(m_stalls);
    sb.push_back(x);
    if (!rst && !e[8] && m_stalls < CNT_MAX) m_stalls++;
  endtask

  task automatic idle();
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_cnt(input string name, input int exp_v);
    @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== CW'(exp_v)) begin
      errors++;
      $display("FAIL %s stall_cnt actual=%0d required=%0d", name, stall_cnt, exp_v);
    end
  endtask

  // Monitor: outputs are presented every cycle; pop one expectation per cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (act !== x.outs) begin
          errors++;
          $display("FAIL outputs t=%0t actual=%b required=%b", $time, act, x.outs);
        end
        checks++;
        if (stall_cnt !== x.cnt) begin
          errors++;
          $display("FAIL stall_cnt t=%0t actual=%0d required=%0d", $time, stall_cnt, x.cnt);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; dmem_ack = 0;
    m_waiting = 0; m_faulted = 0; m_wait_cycles = 0; m_stalls = 0;

    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Load-use on rs2: one bubble.
    step(1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk_cnt("load_use", 1);
    // Same with ex_rd=0: no stall.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk_cnt("load_use_rd0", 1);

    // Delayed ack: three stall cycles.
    repeat (3) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    chk_cnt("delayed_ack", 4);

    // Branch suppresses load-use.
    step(1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk_cnt("branch_load_use", 4);

    // Timeout into FAULT, then long enough in FAULT to saturate the counter.
    repeat (1 + TO) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_cnt("saturate", CNT_MAX);
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Asynchronous reset in the middle of MEM_WAIT.
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (act !== 9'd0) begin
      errors++;
      $display("FAIL async_reset_outs actual=%b required=%b", act, 9'd0);
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset_cnt actual=%0d required=0", stall_cnt);
    end
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk_cnt("after_reset", 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
